// File: rtl/grid_index_codec_if.sv
// rtl/grid_index_codec_if.sv - request/response bundle for the grid index codec
interface grid_index_codec_if #(
  parameter int COORD_W = 7,
  parameter int IDX_W   = 2 * COORD_W
);
  logic               in_valid;
  logic               in_ready;
  logic               in_mode;
  logic [COORD_W-1:0] in_size_x;
  logic [COORD_W-1:0] in_size_y;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic [IDX_W-1:0]   in_index;
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [IDX_W-1:0]   out_index;
  logic [IDX_W-1:0]   out_packed;
  logic               out_err;

  // Requester / consumer side
  modport master (
    output in_valid, in_mode, in_size_x, in_size_y, in_x, in_y, in_index, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_index, out_packed, out_err
  );

  // Codec side
  modport slave (
    input  in_valid, in_mode, in_size_x, in_size_y, in_x, in_y, in_index, out_ready,
    output in_ready, out_valid, out_x, out_y, out_index, out_packed, out_err
  );
endinterface

// File: rtl/grid_index_codec.sv
// rtl/grid_index_codec.sv - (x,y) <-> linear index converter, shift-add multiply / restoring divide
// Optional accept-time and quotient range checks enabled by GRID_CODEC_ERR_EN.
module grid_index_codec #(
  parameter int COORD_W = 7,
  parameter int IDX_W   = 2 * COORD_W
) (
  input logic              clk,
  input logic              rst_n,
  grid_index_codec_if.slave bus
);
  localparam int CNT_W = $clog2(IDX_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] sx_q, sx_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   acc_q, acc_d;
  // Mode 0: y bits shifted out MSB first. Mode 1: dividend shifted out, quotient shifted in.
  logic [IDX_W-1:0]   dq_q, dq_d;
  logic [COORD_W-1:0] rem_q, rem_d;
  logic [COORD_W-1:0] ox_q, ox_d;
  logic [COORD_W-1:0] oy_q, oy_d;
  logic [IDX_W-1:0]   oidx_q, oidx_d;
  logic               oerr_q, oerr_d;
`ifdef GRID_CODEC_ERR_EN
  logic [COORD_W-1:0] sy_q, sy_d;
`endif

  logic               last_mul;
  logic [IDX_W-1:0]   acc_next;
  logic [COORD_W:0]   trial;
  logic               trial_ge;
  logic [COORD_W-1:0] trial_sub;
  logic [IDX_W-1:0]   quo_next;
  logic [COORD_W-1:0] rem_next;

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_x      = ox_q;
  assign bus.out_y      = oy_q;
  assign bus.out_index  = oidx_q;
  assign bus.out_packed = {oy_q, ox_q};
  assign bus.out_err    = oerr_q;

  // Datapath step for one multiply or divide iteration
  always_comb begin
    last_mul  = (cnt_q == CNT_W'(COORD_W - 1));
    acc_next  = (acc_q << 1)
              + (dq_q[IDX_W-1] ? IDX_W'(sx_q) : '0)
              + (last_mul ? IDX_W'(x_q) : '0);
    trial     = {rem_q, dq_q[IDX_W-1]};
    trial_ge  = (trial >= {1'b0, sx_q});
    trial_sub = trial[COORD_W-1:0] - sx_q;
    rem_next  = trial_ge ? trial_sub : trial[COORD_W-1:0];
    quo_next  = {dq_q[IDX_W-2:0], trial_ge};
  end

  // Transaction sequencing and result capture on DONE entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sx_d    = sx_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    dq_d    = dq_q;
    rem_d   = rem_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oidx_d  = oidx_q;
    oerr_d  = oerr_q;
`ifdef GRID_CODEC_ERR_EN
    sy_d    = sy_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sx_d    = bus.in_size_x;
          x_d     = bus.in_x;
          y_d     = bus.in_y;
          idx_d   = bus.in_index;
          cnt_d   = '0;
          acc_d   = '0;
          rem_d   = '0;
          dq_d    = bus.in_mode ? bus.in_index
                                : (IDX_W'(bus.in_y) << (IDX_W - COORD_W));
          state_d = bus.in_mode ? S_DIV : S_MUL;
`ifdef GRID_CODEC_ERR_EN
          sy_d    = bus.in_size_y;
          if (bus.in_mode ? (bus.in_size_x == '0)
                          : ((bus.in_x >= bus.in_size_x) || (bus.in_y >= bus.in_size_y))) begin
            state_d = S_DONE;
            ox_d    = '0;
            oy_d    = '0;
            oidx_d  = '0;
            oerr_d  = 1'b1;
          end
`endif
        end
      end
      S_MUL: begin
        acc_d = acc_next;
        dq_d  = dq_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_mul) begin
          state_d = S_DONE;
          ox_d    = x_q;
          oy_d    = y_q;
          oidx_d  = acc_next;
          oerr_d  = 1'b0;
        end
      end
      S_DIV: begin
        rem_d = rem_next;
        dq_d  = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(IDX_W - 1)) begin
          state_d = S_DONE;
          ox_d    = rem_next;
          oy_d    = quo_next[COORD_W-1:0];
          oidx_d  = idx_q;
          oerr_d  = 1'b0;
`ifdef GRID_CODEC_ERR_EN
          if (quo_next >= IDX_W'(sy_q)) begin
            ox_d   = '0;
            oy_d   = '0;
            oidx_d = '0;
            oerr_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sx_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      dq_q    <= '0;
      rem_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oidx_q  <= '0;
      oerr_q  <= 1'b0;
`ifdef GRID_CODEC_ERR_EN
      sy_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sx_q    <= sx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      dq_q    <= dq_d;
      rem_q   <= rem_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oidx_q  <= oidx_d;
      oerr_q  <= oerr_d;
`ifdef GRID_CODEC_ERR_EN
      sy_q    <= sy_d;
`endif
    end
  end
endmodule

// File: tb/tb_grid_index_codec.sv
// tb/tb_grid_index_codec.sv - self-checking bench for grid_index_codec
module tb_grid_index_codec;
  localparam int W  = 7;
  localparam int IW = 2 * W;
`ifdef GRID_CODEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  grid_index_codec_if #(.COORD_W(W), .IDX_W(IW)) bus ();

  grid_index_codec #(.COORD_W(W), .IDX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.in_mode   = 1'($urandom);
    bus.in_size_x = W'($urandom);
    bus.in_size_y = W'($urandom);
    bus.in_x      = W'($urandom);
    bus.in_y      = W'($urandom);
    bus.in_index  = IW'($urandom);
  endtask

  // Reference: plain integer arithmetic from the conversion rules.
  task automatic model(input bit m, input int sx, input int sy, input int x, input int y,
                       input int idx, output int ex, output int ey, output int eidx,
                       output int eerr, output int elat);
    int q;
    int r;
    ex = 0; ey = 0; eidx = 0; eerr = 0;
    if (m == 1'b0) begin
      if (ERR_EN && (x >= sx || y >= sy)) begin
        eerr = 1; elat = 1;
      end else begin
        ex = x; ey = y; eidx = y * sx + x; elat = W + 1;
      end
    end else begin
      if (ERR_EN && sx == 0) begin
        eerr = 1; elat = 1;
      end else begin
        elat = IW + 1;
        if (sx == 0) begin
          q = (1 << IW) - 1;
          r = idx;
        end else begin
          q = idx / sx;
          r = idx % sx;
        end
        if (ERR_EN && q >= sy) begin
          eerr = 1;
        end else begin
          ex = r % (1 << W); ey = q % (1 << W); eidx = idx;
        end
      end
    end
  endtask

  // One request from a negedge; hold keeps out_ready low that many cycles in DONE.
  task automatic txn(input string tag, input bit m, input int sx, input int sy, input int x,
                     input int y, input int idx, input int hold);
    int ex, ey, eidx, eerr, elat, lat, n;
    model(m, sx, sy, x, y, idx, ex, ey, eidx, eerr, elat);
    bus.out_ready = (hold == 0);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_mode   = m;
    bus.in_size_x = W'(sx);
    bus.in_size_y = W'(sy);
    bus.in_x      = W'(x);
    bus.in_y      = W'(y);
    bus.in_index  = IW'(idx);
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".out_x"}, 32'(bus.out_x), 32'(ex));
    chk({tag, ".out_y"}, 32'(bus.out_y), 32'(ey));
    chk({tag, ".out_index"}, 32'(bus.out_index), 32'(eidx));
    chk({tag, ".out_packed"}, 32'(bus.out_packed), 32'(ey * (1 << W) + ex));
    chk({tag, ".out_err"}, 32'(bus.out_err), 32'(eerr));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      scramble_inputs();
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, ".hold_x"}, 32'(bus.out_x), 32'(ex));
      chk({tag, ".hold_y"}, 32'(bus.out_y), 32'(ey));
      chk({tag, ".hold_index"}, 32'(bus.out_index), 32'(eidx));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".after_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".after_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    scramble_inputs();
    repeat (3) @(negedge clk);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.out_packed", 32'(bus.out_packed), 32'd0);
    chk("reset.out_index", 32'(bus.out_index), 32'd0);
    chk("reset.out_err", 32'(bus.out_err), 32'd0);
    rst_n = 1'b1;

    txn("m0_3_5", 1'b0, 10, 8, 3, 5, 0, 0);
    txn("m1_53", 1'b1, 10, 8, 0, 0, 53, 0);
    txn("m0_max", 1'b0, 127, 127, 126, 126, 0, 0);
    txn("m1_max", 1'b1, 127, 127, 0, 0, 16128, 0);
    txn("m1_80", 1'b1, 10, 8, 0, 0, 80, 0);
    txn("m1_div0", 1'b1, 0, 8, 0, 0, 12345, 0);
    txn("m0_xedge", 1'b0, 10, 8, 10, 2, 0, 0);
    txn("m0_hold", 1'b0, 10, 8, 7, 4, 0, 5);
    txn("m1_after_hold", 1'b1, 9, 20, 0, 0, 100, 0);

    for (int i = 0; i < 24; i++) begin
      txn("rand", 1'($urandom), $urandom_range(0, 127), $urandom_range(0, 127),
          $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, (1 << IW) - 1), 0);
    end

    // Reset while dividing: transaction must vanish.
    bus.in_mode   = 1'b1;
    bus.in_size_x = W'(10);
    bus.in_size_y = W'(8);
    bus.in_index  = IW'(53);
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("midreset.out_packed", 32'(bus.out_packed), 32'd0);
    chk("midreset.out_index", 32'(bus.out_index), 32'd0);
    chk("midreset.out_err", 32'(bus.out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("midreset.no_pulse", 32'(seen), 32'd0);
    txn("post_reset", 1'b0, 10, 8, 3, 5, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
